// File: rtl/if_stage.sv
// Instruction fetch stage: PC, imem req/ready handshake, IF/ID register, one-entry skid buffer.
// Optional IF_STATS_EN adds fetch_count/squash_count outputs.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
`ifdef IF_STATS_EN
  output logic [31:0] fetch_count,
  output logic [31:0] squash_count,
`endif
  output logic [5:0]  opcode
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_BUF,
    S_DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_state_n;
  logic [31:0] r_pc;
  logic [31:0] r_drain_addr;
  logic        r_ifid_valid;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc4;

  logic [31:0] w_pc_n;
  logic [31:0] w_drain_addr_n;
  logic        w_ifid_valid_n;
  logic [31:0] w_ifid_instr_n;
  logic [31:0] w_ifid_pc4_n;
  logic [31:0] w_buf_instr_n;
  logic [31:0] w_buf_pc4_n;
  logic [31:0] w_pc4;
  logic [31:0] w_redirect_pc;
  logic        w_accept;

  assign w_pc4         = r_pc + 32'd4;
  assign w_redirect_pc = redirect_pc & ~32'h3;
  assign w_accept      = !r_ifid_valid || !id_stall;

  assign imem_req   = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign imem_addr  = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
  assign ifid_valid = r_ifid_valid;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc4   = r_ifid_pc4;
  assign opcode     = r_ifid_instr[31:26];

  always_comb begin
    w_state_n      = r_state;
    w_pc_n         = r_pc;
    w_drain_addr_n = r_drain_addr;
    w_ifid_valid_n = r_ifid_valid;
    w_ifid_instr_n = r_ifid_instr;
    w_ifid_pc4_n   = r_ifid_pc4;
    w_buf_instr_n  = r_buf_instr;
    w_buf_pc4_n    = r_buf_pc4;
    if (redirect && r_state != S_IDLE) begin
      w_ifid_valid_n = 1'b0;
      w_ifid_instr_n = 32'h0;
      w_pc_n         = w_redirect_pc;
      w_state_n      = S_FETCH;
      // An unanswered request must still be absorbed before refetching
      if (r_state == S_FETCH && !imem_ready) begin
        w_state_n      = S_DRAIN;
        w_drain_addr_n = r_pc;
      end else if (r_state == S_DRAIN && !imem_ready) begin
        w_state_n      = S_DRAIN;
      end
    end else begin
      unique case (r_state)
        S_IDLE: w_state_n = S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            w_pc_n = w_pc4;
            if (w_accept) begin
              w_ifid_valid_n = 1'b1;
              w_ifid_instr_n = imem_rdata;
              w_ifid_pc4_n   = w_pc4;
            end else begin
              w_buf_instr_n = imem_rdata;
              w_buf_pc4_n   = w_pc4;
              w_state_n     = S_BUF;
            end
          end else if (w_accept) begin
            w_ifid_valid_n = 1'b0;
            w_ifid_instr_n = 32'h0;
          end
        end
        S_BUF: begin
          if (!id_stall) begin
            w_ifid_valid_n = 1'b1;
            w_ifid_instr_n = r_buf_instr;
            w_ifid_pc4_n   = r_buf_pc4;
            w_state_n      = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_ready) w_state_n = S_FETCH;
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_drain_addr <= 32'h0;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= 32'h0;
      r_ifid_pc4   <= 32'h0;
      r_buf_instr  <= 32'h0;
      r_buf_pc4    <= 32'h0;
    end else begin
      r_pc         <= w_pc_n;
      r_drain_addr <= w_drain_addr_n;
      r_ifid_valid <= w_ifid_valid_n;
      r_ifid_instr <= w_ifid_instr_n;
      r_ifid_pc4   <= w_ifid_pc4_n;
      r_buf_instr  <= w_buf_instr_n;
      r_buf_pc4    <= w_buf_pc4_n;
    end
  end

`ifdef IF_STATS_EN
  logic        w_fetch_ok;
  logic        w_squash;
  logic [31:0] w_squash_amt;
  logic [31:0] r_fetch_count;
  logic [31:0] r_squash_count;

  assign w_fetch_ok   = (r_state == S_FETCH) && imem_ready && !redirect;
  assign w_squash     = redirect && (r_state != S_IDLE);
  // A held buffer entry is squashed alongside the IF/ID entry
  assign w_squash_amt = {31'h0, r_ifid_valid}
                      + {31'h0, r_state == S_BUF};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count  <= 32'h0;
      r_squash_count <= 32'h0;
    end else begin
      if (w_fetch_ok) r_fetch_count <= r_fetch_count + 32'd1;
      if (w_squash)   r_squash_count <= r_squash_count + w_squash_amt;
    end
  end

  assign fetch_count  = r_fetch_count;
  assign squash_count = r_squash_count;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: scoreboard queue of expected IF/ID entries,
// popped by a monitor whenever decode consumes a valid entry.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [5:0]  opcode;
`ifdef IF_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] squash_count;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [31:0] I_LW    = 32'h8C08_0000;
  localparam logic [31:0] I_ADDI  = 32'h2009_0001;
  localparam logic [31:0] I_ADD   = 32'h0109_5020;
  localparam logic [31:0] I_LUI   = 32'h3C01_1234;
  localparam logic [31:0] I_BEQ   = 32'h1000_0003;
  localparam logic [31:0] I_J     = 32'h0800_0400;
  localparam logic [31:0] I_DEAD  = 32'hDEAD_BEEF;
  localparam logic [31:0] I_ADDIU = 32'h2402_0005;
  localparam logic [31:0] I_DROP  = 32'h1111_1111;
  localparam logic [31:0] I_SW    = 32'hAC0A_0000;
  localparam logic [31:0] I_JAL   = 32'h0C00_0010;

  if_stage #(.RESET_PC(32'h0040_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .id_stall    (id_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
`ifdef IF_STATS_EN
    .fetch_count (fetch_count),
    .squash_count(squash_count),
`endif
    .opcode      (opcode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle: check request outputs, then drive this cycle's inputs.
  task automatic cyc(input logic ereq, input logic [31:0] eaddr,
                     input logic rdy, input logic [31:0] d,
                     input logic st, input logic rd,
                     input logic [31:0] rpc,
                     input logic push, input logic [31:0] epc4);
    exp_t e;
    @(posedge clk);
    #1;
    chk("imem_req", {31'h0, imem_req}, {31'h0, ereq});
    if (ereq) chk("imem_addr", imem_addr, eaddr);
    imem_ready  = rdy;
    imem_rdata  = d;
    id_stall    = st;
    redirect    = rd;
    redirect_pc = rpc;
    if (push) begin
      e.instr = d;
      e.pc4   = epc4;
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (ifid_valid === 1'b1 && id_stall === 1'b0) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_instr: got %h, expected none",
                 ifid_instr);
      end else begin
        m_e = q.pop_front();
        chk("ifid_instr", ifid_instr, m_e.instr);
        chk("ifid_pc4", ifid_pc4, m_e.pc4);
        chk("opcode", {26'h0, opcode}, {26'h0, m_e.instr[31:26]});
      end
    end else if (ifid_valid === 1'b0 && reset === 1'b0) begin
      chk("bubble_instr", ifid_instr, 32'h0);
    end
  end

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_pc4", ifid_pc4, 32'h0);
    chk("rst_opcode", {26'h0, opcode}, 32'h0);
`ifdef IF_STATS_EN
    chk("rst_fetch_count", fetch_count, 32'h0);
    chk("rst_squash_count", squash_count, 32'h0);
`endif
    reset = 1'b0;

    // Back-to-back fetches from RESET_PC
    cyc(1, 32'h0040_0000, 1, I_LW,   0, 0, 0, 1, 32'h0040_0004);
    cyc(1, 32'h0040_0004, 1, I_ADDI, 0, 0, 0, 1, 32'h0040_0008);
    cyc(1, 32'h0040_0008, 1, I_ADD,  0, 0, 0, 1, 32'h0040_000C);

    // Memory answers three cycles late
    cyc(1, 32'h0040_000C, 0, 0,      0, 0, 0, 0, 0);
    cyc(1, 32'h0040_000C, 0, 0,      0, 0, 0, 0, 0);
    chk("late_valid1", {31'h0, ifid_valid}, 32'h0);
    cyc(1, 32'h0040_000C, 0, 0,      0, 0, 0, 0, 0);
    chk("late_valid2", {31'h0, ifid_valid}, 32'h0);
    cyc(1, 32'h0040_000C, 1, I_LUI,  0, 0, 0, 1, 32'h0040_0010);
    chk("late_valid3", {31'h0, ifid_valid}, 32'h0);

    // Stall while a fetch completes: skid into the buffer
    cyc(1, 32'h0040_0010, 1, I_BEQ,  1, 0, 0, 1, 32'h0040_0014);
    cyc(0, 0,             0, 0,      1, 0, 0, 0, 0);
    chk("buf_hold1", ifid_instr, I_LUI);
    cyc(0, 0,             0, 0,      1, 0, 0, 0, 0);
    chk("buf_hold2", ifid_instr, I_LUI);
    cyc(0, 0,             0, 0,      1, 0, 0, 0, 0);
    chk("buf_hold3", ifid_instr, I_LUI);
    cyc(0, 0,             0, 0,      0, 0, 0, 0, 0);
`ifdef IF_STATS_EN
    chk("fetch_count5", fetch_count, 32'd5);
`endif
    cyc(1, 32'h0040_0014, 1, I_J,    0, 0, 0, 1, 32'h0040_0018);

    // Redirect while a fetch is outstanding: drain the late data
    cyc(1, 32'h0040_0018, 0, 0,      0, 1, 32'h0000_1002, 0, 0);
    cyc(1, 32'h0040_0018, 0, 0,      0, 0, 0, 0, 0);
    chk("drain_valid", {31'h0, ifid_valid}, 32'h0);
`ifdef IF_STATS_EN
    chk("squash_count1", squash_count, 32'd1);
`endif
    cyc(1, 32'h0040_0018, 1, I_DEAD, 0, 0, 0, 0, 0);
    cyc(1, 32'h0000_1000, 1, I_ADDIU, 0, 0, 0, 1, 32'h0000_1004);

    // Redirect with ready in the same cycle, then wrap past 0xFFFFFFFC
    cyc(1, 32'h0000_1004, 1, I_DROP, 0, 1, 32'hFFFF_FFFC, 0, 0);
    cyc(1, 32'hFFFF_FFFC, 1, I_SW,   0, 0, 0, 1, 32'h0000_0000);
    chk("redir_valid", {31'h0, ifid_valid}, 32'h0);
    cyc(1, 32'h0000_0000, 1, I_JAL,  0, 0, 0, 1, 32'h0000_0004);
    cyc(1, 32'h0000_0004, 0, 0,      0, 0, 0, 0, 0);

    // Reset mid-request
    @(posedge clk);
    #1;
`ifdef IF_STATS_EN
    chk("fetch_count9", fetch_count, 32'd9);
    chk("squash_count2", squash_count, 32'd2);
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    chk("mid_rst_valid", {31'h0, ifid_valid}, 32'h0);
`ifdef IF_STATS_EN
    chk("mid_rst_fetch_count", fetch_count, 32'h0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_req", {31'h0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0040_0000);
    @(negedge clk);
    chk("queue_empty", q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage for the single-issue MIPS core. Holds the program counter and issues word requests to instruction memory over a req/ready handshake. Fetched instructions go into the IF/ID pipeline register; its `opcode` field drives the main control decoder directly. Absorbs decode stalls with a one-entry skid buffer, and handles redirects (branch/jump) by squashing wrong-path instructions and dropping any in-flight memory response.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  word address of the request; bits [1:0] always 0.
- `imem_ready`  in  1  memory completes the request this cycle; `imem_rdata` is valid.
- `imem_rdata`  in  32  instruction word.
- `id_stall`  in  1  decode cannot accept a new instruction; IF/ID holds.
- `redirect`  in  1  branch/jump taken; squash the wrong path.
- `redirect_pc`  in  32  new fetch PC; bits [1:0] ignored (treated as 0).
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `ifid_instr`  out  32  IF/ID instruction; 32'h0000_0000 (nop) when not valid.
- `ifid_pc4`  out  32  PC+4 of the IF/ID instruction.
- `opcode`  out  6  `ifid_instr[31:26]`, feeds the control decoder.

## Operation
- States: IDLE, FETCH, BUF, DRAIN.
- Reset: state=IDLE, pc=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc4=0, buffer empty. `imem_req`=0. `opcode`=0.
- IDLE: goes to FETCH on the next cycle. `imem_req`=0.
- FETCH: `imem_req`=1 and `imem_addr`=pc. While `imem_ready`=0, `imem_addr` stays stable.
- FETCH with `imem_ready`=1 and no redirect:
  - pc <= pc+4.
  - If IF/ID can accept (`ifid_valid`=0 or `id_stall`=0): IF/ID <= {rdata, pc+4, valid=1}; stay in FETCH.
  - Otherwise: buffer <= {rdata, pc+4}; go to BUF.
- FETCH with `imem_ready`=0 and no redirect: if IF/ID can accept, load a bubble (valid=0, instr=0).
- BUF: `imem_req`=0. When `id_stall`=0, IF/ID <= buffer (valid=1) and go to FETCH.
- Redirect has the highest priority and applies in every state except IDLE:
  - IF/ID <= bubble; buffer discarded; pc <= {redirect_pc[31:2],2'b00}.
  - From FETCH with `imem_ready`=0 (request outstanding): go to DRAIN.
  - Otherwise: go to FETCH.
- DRAIN: `imem_req`=1 with the old address held. When `imem_ready`=1, data is dropped and state goes to FETCH. A redirect in DRAIN updates pc and stays in DRAIN.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- `id_stall` with `ifid_valid`=0 is ignored, so a bubble is always replaceable.

## Timing
- Throughput: one instruction per cycle when `imem_ready` is held 1 and there are no stalls.
- Latency: an instruction is visible on `ifid_*`/`opcode` the cycle after its `imem_ready` cycle.
- Redirect asserted in cycle N with no request outstanding: `imem_addr`=redirect_pc in N+1, and `ifid_valid`=0 in N+1.
- Redirect in cycle N with a request outstanding: the new address is presented the cycle after the old request's `imem_ready`.
- Redirect and `imem_ready` in the same cycle: the returned data is dropped and state goes to FETCH (no DRAIN).
- BUF release: buffered instruction appears on IF/ID the cycle after `id_stall` falls; the next request is issued in that same cycle.
- Reset mid-operation: any outstanding request is abandoned. Instruction memory shares `reset` and must abort as well.

## Configuration
- `IF_STATS_EN` defined: adds output ports `fetch_count` (32) and `squash_count` (32), both reset to 0 and wrapping.
  - `fetch_count` increments on every accepted (non-dropped) `imem_ready`.
  - `squash_count` increments for each valid IF/ID entry or buffer entry discarded by a redirect.
- `IF_STATS_EN` undefined: the counters and ports are absent; behaviour is otherwise identical.

## Test plan
- Reset with RESET_PC=32'h0040_0000, `imem_ready` tied 1: `imem_addr` steps 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; `ifid_pc4` follows one cycle behind; `opcode` matches rdata[31:26].
- Memory responds 3 cycles late: `imem_addr` is held for 3 cycles, `ifid_valid`=0 throughout, then one valid instruction appears.
- `id_stall`=1 for 4 cycles while a fetch completes: state goes to BUF, `imem_req`=0, IF/ID unchanged; on release the buffered instruction appears, then the next fetch follows.
- Redirect to 0x00001002 while a fetch is pending: DRAIN drops the late data; the next `imem_addr`=0x00001000; the squashed instruction never appears on IF/ID.
- PC=32'hFFFF_FFFC fetch: the next `imem_addr`=0x00000000. Redirect plus `imem_ready` in the same cycle: data dropped, no DRAIN.
- With `IF_STATS_EN`: 5 fetches and 1 redirect over a valid IF/ID give `fetch_count`=5 and `squash_count`=1.
